// File: rtl/rv_lsu_pkg.sv
// Shared types and decode helpers for the serial load/store unit.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package rv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Access size in bytes; the low two funct3 bits carry the size for all legal codes.
    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = !we;
            default:          is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   is_aligned = !addr_lo[0];
            2'b10:   is_aligned = (addr_lo == 2'b00);
            default: is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for one memory beat: byte enables, store replication, load gather and extension.
// Latency: purely combinational.
// Backpressure: none; the owning FSM holds the inputs stable while a beat is stalled.
// Ports: funct3/addr_lo/beat describe the access, wdata is rs2, acc/dout feed the load
//        accumulator (acc_next), be/din drive the memory, rdata is the extended result of acc.
module lsu_align #(
    parameter int MEM_W = 8
) (
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    input  logic [1:0]         beat,
    input  logic [31:0]        wdata,
    input  logic [31:0]        acc,
    input  logic [MEM_W-1:0]   dout,
    output logic [MEM_W/8-1:0] be,
    output logic [MEM_W-1:0]   din,
    output logic [31:0]        acc_next,
    output logic [31:0]        rdata
);
    import rv_lsu_pkg::*;

    localparam int LANES = MEM_W / 8;
    localparam int BE_W  = MEM_W / 8;

    int         nbytes;
    int         shift;
    logic [1:0] lane;

    always_comb begin
        nbytes   = int'(access_bytes(funct3));
        lane     = addr_lo & 2'(LANES - 1);
        shift    = int'(beat) * MEM_W;
        // Wide access: full-width beats, each carrying the next slice of the word.
        be       = '1;
        din      = MEM_W'(wdata >> shift);
        acc_next = acc | (32'(dout) << shift);
        if (nbytes < LANES) begin
            // Narrow access: one beat, lanes picked by the low address bits.
            be = BE_W'(((1 << nbytes) - 1) << lane);
            for (int i = 0; i < LANES; i++) begin
                din[i*8 +: 8] = wdata[((nbytes == 2) ? (i % 2) : 0) * 8 +: 8];
            end
            acc_next = acc | (32'(dout) >> (int'(lane) * 8));
        end
    end

    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{acc[7]}}, acc[7:0]};
            F3_H:    rdata = {{16{acc[15]}}, acc[15:0]};
            F3_BU:   rdata = {24'b0, acc[7:0]};
            F3_HU:   rdata = {16'b0, acc[15:0]};
            default: rdata = acc;
        endcase
    end

endmodule

// File: rtl/rv_lsu_serial.sv
// RV32I load/store unit: splits each access into MEM_W-wide beats on a valid/ready memory port.
// Latency: accept, then one cycle per beat (plus stalls), then a one-cycle response; errors respond next cycle.
// Backpressure: req_ready only in IDLE; beats hold addr/be/din until dmem_ready or the optional timeout.
// Ports: sysclk/sysreset (async active-low), req_* core request, rsp_* completion pulse, dmem_* memory beat port.
module rv_lsu_serial #(
    parameter int MEM_W   = 8,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic               sysclk,
    input  logic               sysreset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               dmem_valid,
    input  logic               dmem_ready,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [MEM_W/8-1:0] dmem_be,
    output logic [MEM_W-1:0]   dmem_din,
    input  logic [MEM_W-1:0]   dmem_dout
);
    import rv_lsu_pkg::*;

    localparam int LANES = MEM_W / 8;

    lsu_state_e          state;
    lsu_state_e          state_nxt;
    logic                we_q;
    logic                err_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         acc_q;
    logic [1:0]          beat_q;
    logic [1:0]          last_beat;
    logic [31:0]         wait_q;
    logic                req_err;
    logic                timeout_hit;
    int                  nbytes;
    logic [MEM_W/8-1:0]  be_w;
    logic [MEM_W-1:0]    din_w;
    logic [31:0]         acc_nxt;
    logic [31:0]         rdata_w;

    lsu_align #(.MEM_W(MEM_W)) u_align (
        .funct3   (f3_q),
        .addr_lo  (addr_q[1:0]),
        .beat     (beat_q),
        .wdata    (wdata_q),
        .acc      (acc_q),
        .dout     (dmem_dout),
        .be       (be_w),
        .din      (din_w),
        .acc_next (acc_nxt),
        .rdata    (rdata_w)
    );

    assign req_err     = !is_legal(req_we, req_funct3) || !is_aligned(req_funct3, req_addr[1:0]);
    // Fires on the cycle the wait counter has already seen TIMEOUT-1 idle cycles.
    assign timeout_hit = (TIMEOUT > 0) && !dmem_ready && (wait_q == 32'(TIMEOUT - 1));

    always_comb begin
        nbytes    = int'(access_bytes(f3_q));
        last_beat = (nbytes <= LANES) ? 2'd0 : 2'(nbytes / LANES - 1);
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        dmem_valid = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_din   = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? ST_RESP : ST_XFER;
            end
            ST_XFER: begin
                dmem_valid = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = (addr_q & ~ADDR_W'(LANES - 1)) + ADDR_W'(int'(beat_q) * LANES);
                dmem_be    = be_w;
                dmem_din   = din_w;
                if ((dmem_ready && beat_q == last_beat) || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? '0 : rdata_w;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        acc_q   <= '0;
                        beat_q  <= '0;
                        wait_q  <= '0;
                    end
                end
                ST_XFER: begin
                    if (dmem_ready) begin
                        wait_q <= '0;
                        beat_q <= beat_q + 2'd1;
                        if (!we_q) acc_q <= acc_nxt;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_lsu_serial.sv
// Directed bench: three unit instances (8-bit, 32-bit, 16-bit with timeout) against a byte memory.
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge.
// Backpressure: dmem_ready per instance is driven directly by each scenario.
module tb_rv_lsu_serial;

    logic sysclk = 1'b0;
    logic sysreset;
    always #5 sysclk = ~sysclk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  mem [1024];
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_valid_8, req_ready_8, rsp_valid_8, rsp_err_8, dmem_valid_8, dmem_ready_8, dmem_we_8;
    logic [31:0] rsp_rdata_8, dmem_addr_8;
    logic [0:0]  dmem_be_8;
    logic [7:0]  dmem_din_8, dmem_dout_8;

    logic        req_valid_32, req_ready_32, rsp_valid_32, rsp_err_32, dmem_valid_32, dmem_ready_32, dmem_we_32;
    logic [31:0] rsp_rdata_32, dmem_addr_32, dmem_din_32, dmem_dout_32;
    logic [3:0]  dmem_be_32;

    logic        req_valid_16, req_ready_16, rsp_valid_16, rsp_err_16, dmem_valid_16, dmem_ready_16, dmem_we_16;
    logic [31:0] rsp_rdata_16, dmem_addr_16;
    logic [1:0]  dmem_be_16;
    logic [15:0] dmem_din_16, dmem_dout_16;

    logic [9:0] a8, a16, a32;
    assign a8  = dmem_addr_8[9:0];
    assign a16 = dmem_addr_16[9:0];
    assign a32 = dmem_addr_32[9:0];
    assign dmem_dout_8  = mem[a8];
    assign dmem_dout_16 = {mem[a16 + 10'd1], mem[a16]};
    assign dmem_dout_32 = {mem[a32 + 10'd3], mem[a32 + 10'd2], mem[a32 + 10'd1], mem[a32]};

    rv_lsu_serial #(.MEM_W(8), .ADDR_W(32), .TIMEOUT(0)) u8 (
        .sysclk(sysclk), .sysreset(sysreset), .req_valid(req_valid_8), .req_ready(req_ready_8),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_8), .rsp_rdata(rsp_rdata_8), .rsp_err(rsp_err_8),
        .dmem_valid(dmem_valid_8), .dmem_ready(dmem_ready_8), .dmem_we(dmem_we_8), .dmem_addr(dmem_addr_8),
        .dmem_be(dmem_be_8), .dmem_din(dmem_din_8), .dmem_dout(dmem_dout_8));

    rv_lsu_serial #(.MEM_W(32), .ADDR_W(32), .TIMEOUT(0)) u32 (
        .sysclk(sysclk), .sysreset(sysreset), .req_valid(req_valid_32), .req_ready(req_ready_32),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_32), .rsp_rdata(rsp_rdata_32), .rsp_err(rsp_err_32),
        .dmem_valid(dmem_valid_32), .dmem_ready(dmem_ready_32), .dmem_we(dmem_we_32), .dmem_addr(dmem_addr_32),
        .dmem_be(dmem_be_32), .dmem_din(dmem_din_32), .dmem_dout(dmem_dout_32));

    rv_lsu_serial #(.MEM_W(16), .ADDR_W(32), .TIMEOUT(4)) u16 (
        .sysclk(sysclk), .sysreset(sysreset), .req_valid(req_valid_16), .req_ready(req_ready_16),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_16), .rsp_rdata(rsp_rdata_16), .rsp_err(rsp_err_16),
        .dmem_valid(dmem_valid_16), .dmem_ready(dmem_ready_16), .dmem_we(dmem_we_16), .dmem_addr(dmem_addr_16),
        .dmem_be(dmem_be_16), .dmem_din(dmem_din_16), .dmem_dout(dmem_dout_16));

    task automatic test_reset();
        sysreset = 1'b1;
        #1 sysreset = 1'b0;
        #2;
        vectors++;
        if (req_ready_8 !== 1'b1 || {rsp_valid_8, rsp_err_8, rsp_rdata_8, dmem_valid_8, dmem_we_8,
                                     dmem_addr_8, dmem_be_8, dmem_din_8} !== '0) begin
            miscompares++;
            $display("FAIL reset_w8: ready=%b valid=%b addr=%h be=%b din=%h, want ready=1 rest 0",
                     req_ready_8, dmem_valid_8, dmem_addr_8, dmem_be_8, dmem_din_8);
        end
        vectors++;
        if (req_ready_32 !== 1'b1 || {rsp_valid_32, rsp_err_32, rsp_rdata_32, dmem_valid_32, dmem_we_32,
                                      dmem_addr_32, dmem_be_32, dmem_din_32} !== '0) begin
            miscompares++;
            $display("FAIL reset_w32: ready=%b valid=%b addr=%h be=%b, want ready=1 rest 0",
                     req_ready_32, dmem_valid_32, dmem_addr_32, dmem_be_32);
        end
        vectors++;
        if (req_ready_16 !== 1'b1 || {rsp_valid_16, rsp_err_16, rsp_rdata_16, dmem_valid_16, dmem_we_16,
                                      dmem_addr_16, dmem_be_16, dmem_din_16} !== '0) begin
            miscompares++;
            $display("FAIL reset_w16: ready=%b valid=%b addr=%h be=%b, want ready=1 rest 0",
                     req_ready_16, dmem_valid_16, dmem_addr_16, dmem_be_16);
        end
        @(negedge sysclk);
        sysreset = 1'b1;
    endtask

    // SW 0xDEADBEEF on the byte bus: four beats, little-endian, response in cycle 5.
    task automatic test_store_w8();
        logic [7:0] exp_din [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        @(negedge sysclk);
        vectors++;
        if (req_ready_8 !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_w8_ready: got %b want 1", req_ready_8);
        end
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
        req_valid_8 = 1'b1; dmem_ready_8 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge sysclk);
            req_valid_8 = 1'b0;
            vectors++;
            if (c <= 4) begin
                if ({dmem_valid_8, dmem_we_8, dmem_addr_8, dmem_be_8, dmem_din_8, rsp_valid_8} !==
                    {1'b1, 1'b1, 32'h100 + 32'(c - 1), 1'b1, exp_din[c-1], 1'b0}) begin
                    miscompares++;
                    $display("FAIL sw_w8_beat%0d: valid=%b we=%b addr=%h be=%b din=%h rsp=%b, want 1 1 %h 1 %h 0",
                             c, dmem_valid_8, dmem_we_8, dmem_addr_8, dmem_be_8, dmem_din_8, rsp_valid_8,
                             32'h100 + 32'(c - 1), exp_din[c-1]);
                end
            end else begin
                if ({rsp_valid_8, rsp_err_8, rsp_rdata_8, dmem_valid_8} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL sw_w8_rsp: valid=%b err=%b rdata=%h dmem_valid=%b, want 1 0 0 0",
                             rsp_valid_8, rsp_err_8, rsp_rdata_8, dmem_valid_8);
                end
            end
        end
        @(negedge sysclk);
        vectors++;
        if ({rsp_valid_8, req_ready_8} !== 2'b01) begin
            miscompares++;
            $display("FAIL sw_w8_after: rsp_valid=%b req_ready=%b, want 0 1", rsp_valid_8, req_ready_8);
        end
    endtask

    // Multi-beat loads on the byte bus: reassembly plus sign/zero extension.
    task automatic test_load_w8();
        logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b101};
        logic [31:0] ad [3] = '{32'h100, 32'h106, 32'h106};
        int          nb [3] = '{4, 2, 2};
        logic [31:0] rd [3] = '{32'h12345678, 32'hFFFFF234, 32'h0000F234};
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            req_we = 1'b0; req_funct3 = f3[i]; req_addr = ad[i]; req_wdata = 32'hFFFF_FFFF;
            req_valid_8 = 1'b1; dmem_ready_8 = 1'b1;
            for (int c = 1; c <= nb[i]; c++) begin
                @(negedge sysclk);
                req_valid_8 = 1'b0;
                vectors++;
                if ({dmem_valid_8, dmem_we_8, dmem_addr_8, rsp_valid_8} !== {1'b1, 1'b0, ad[i] + 32'(c - 1), 1'b0}) begin
                    miscompares++;
                    $display("FAIL ld_w8[%0d]_beat%0d: valid=%b we=%b addr=%h rsp=%b, want 1 0 %h 0",
                             i, c, dmem_valid_8, dmem_we_8, dmem_addr_8, rsp_valid_8, ad[i] + 32'(c - 1));
                end
            end
            @(negedge sysclk);
            vectors++;
            if ({rsp_valid_8, rsp_err_8, rsp_rdata_8} !== {2'b10, rd[i]}) begin
                miscompares++;
                $display("FAIL ld_w8[%0d]_rsp: valid=%b err=%b rdata=%h, want 1 0 %h",
                         i, rsp_valid_8, rsp_err_8, rsp_rdata_8, rd[i]);
            end
        end
    endtask

    // Single-beat sub-word accesses on the 32-bit bus; memory word at 0x200 is 0x80332211.
    task automatic test_narrow_w32();
        logic        we  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000, 3'b001};
        logic [31:0] ad  [8] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h200, 32'h201, 32'h202};
        logic [31:0] wd  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h123456AB, 32'h9999BEEF};
        logic [3:0]  bex [8] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0001, 4'b0010, 4'b1100};
        logic [31:0] dix [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hABABABAB, 32'hBEEFBEEF};
        logic [31:0] rdx [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8033, 32'h00008033,
                                 32'h80332211, 32'h00000011, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk);
            req_we = we[i]; req_funct3 = f3[i]; req_addr = ad[i]; req_wdata = wd[i];
            req_valid_32 = 1'b1; dmem_ready_32 = 1'b1;
            @(negedge sysclk);
            req_valid_32 = 1'b0;
            vectors++;
            if ({dmem_valid_32, dmem_we_32, dmem_addr_32, dmem_be_32} !== {1'b1, we[i], 32'h200, bex[i]}) begin
                miscompares++;
                $display("FAIL w32[%0d]_beat: valid=%b we=%b addr=%h be=%b, want 1 %b 00000200 %b",
                         i, dmem_valid_32, dmem_we_32, dmem_addr_32, dmem_be_32, we[i], bex[i]);
            end
            if (we[i]) begin
                vectors++;
                if (dmem_din_32 !== dix[i]) begin
                    miscompares++;
                    $display("FAIL w32[%0d]_din: got %h want %h", i, dmem_din_32, dix[i]);
                end
            end
            @(negedge sysclk);
            vectors++;
            if ({rsp_valid_32, rsp_err_32, rsp_rdata_32} !== {2'b10, rdx[i]}) begin
                miscompares++;
                $display("FAIL w32[%0d]_rsp: valid=%b err=%b rdata=%h, want 1 0 %h",
                         i, rsp_valid_32, rsp_err_32, rsp_rdata_32, rdx[i]);
            end
        end
    endtask

    // Misaligned and illegal requests: error response in cycle 1, no beats.
    task automatic test_errors();
        logic        we [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [7] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110};
        logic [31:0] ad [7] = '{32'h101, 32'h102, 32'h103, 32'h101, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 7; i++) begin
            @(negedge sysclk);
            req_we = we[i]; req_funct3 = f3[i]; req_addr = ad[i]; req_wdata = 32'h5555AAAA;
            req_valid_8 = 1'b1; dmem_ready_8 = 1'b1;
            @(negedge sysclk);
            req_valid_8 = 1'b0;
            vectors++;
            if ({rsp_valid_8, rsp_err_8, rsp_rdata_8, dmem_valid_8, req_ready_8} !== {2'b11, 32'h0, 2'b00}) begin
                miscompares++;
                $display("FAIL err[%0d]_rsp: valid=%b err=%b rdata=%h dmem_valid=%b ready=%b, want 1 1 0 0 0",
                         i, rsp_valid_8, rsp_err_8, rsp_rdata_8, dmem_valid_8, req_ready_8);
            end
            @(negedge sysclk);
            vectors++;
            if ({rsp_valid_8, dmem_valid_8, req_ready_8} !== 3'b001) begin
                miscompares++;
                $display("FAIL err[%0d]_after: rsp=%b dmem_valid=%b ready=%b, want 0 0 1",
                         i, rsp_valid_8, dmem_valid_8, req_ready_8);
            end
        end
    endtask

    // LW on the 16-bit bus with dmem_ready low through cycle 2: beat 0 held, response in cycle 5.
    task automatic test_stall_w16();
        logic [31:0] exp_addr [5] = '{32'h300, 32'h300, 32'h300, 32'h302, 32'h0};
        @(negedge sysclk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h0;
        req_valid_16 = 1'b1; dmem_ready_16 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge sysclk);
            req_valid_16 = 1'b0;
            vectors++;
            if (c <= 4) begin
                if ({dmem_valid_16, dmem_we_16, dmem_addr_16, dmem_be_16, rsp_valid_16} !==
                    {2'b10, exp_addr[c-1], 2'b11, 1'b0}) begin
                    miscompares++;
                    $display("FAIL stall_w16_c%0d: valid=%b we=%b addr=%h be=%b rsp=%b, want 1 0 %h 11 0",
                             c, dmem_valid_16, dmem_we_16, dmem_addr_16, dmem_be_16, rsp_valid_16, exp_addr[c-1]);
                end
            end else begin
                if ({rsp_valid_16, rsp_err_16, rsp_rdata_16, dmem_valid_16} !== {2'b10, 32'h84030201, 1'b0}) begin
                    miscompares++;
                    $display("FAIL stall_w16_rsp: valid=%b err=%b rdata=%h dmem_valid=%b, want 1 0 84030201 0",
                             rsp_valid_16, rsp_err_16, rsp_rdata_16, dmem_valid_16);
                end
            end
            if (c >= 3) dmem_ready_16 = 1'b1;
        end
    endtask

    // SW on the 16-bit bus with dmem_ready never asserted: four beat cycles, then an error response.
    task automatic test_timeout_w16();
        @(negedge sysclk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h310; req_wdata = 32'hCAFEBEEF;
        req_valid_16 = 1'b1; dmem_ready_16 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge sysclk);
            req_valid_16 = 1'b0;
            vectors++;
            if (c <= 4) begin
                if ({dmem_valid_16, dmem_we_16, dmem_addr_16, dmem_be_16, dmem_din_16, rsp_valid_16} !==
                    {2'b11, 32'h310, 2'b11, 16'hBEEF, 1'b0}) begin
                    miscompares++;
                    $display("FAIL tmo_w16_c%0d: valid=%b we=%b addr=%h be=%b din=%h rsp=%b, want 1 1 310 11 beef 0",
                             c, dmem_valid_16, dmem_we_16, dmem_addr_16, dmem_be_16, dmem_din_16, rsp_valid_16);
                end
            end else if (c == 5) begin
                if ({dmem_valid_16, rsp_valid_16, rsp_err_16, rsp_rdata_16} !== {3'b011, 32'h0}) begin
                    miscompares++;
                    $display("FAIL tmo_w16_rsp: dmem_valid=%b valid=%b err=%b rdata=%h, want 0 1 1 0",
                             dmem_valid_16, rsp_valid_16, rsp_err_16, rsp_rdata_16);
                end
            end else begin
                if ({rsp_valid_16, req_ready_16} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL tmo_w16_after: rsp=%b ready=%b, want 0 1", rsp_valid_16, req_ready_16);
                end
            end
        end
    endtask

    // Reset asserted during the third beat of an LW: outputs clear at once, no response follows.
    task automatic test_reset_midbeat();
        int seen = 0;
        @(negedge sysclk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
        req_valid_8 = 1'b1; dmem_ready_8 = 1'b1;
        @(negedge sysclk);
        req_valid_8 = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        vectors++;
        if ({dmem_valid_8, dmem_addr_8} !== {1'b1, 32'h102}) begin
            miscompares++;
            $display("FAIL rst_mid_beat2: valid=%b addr=%h, want 1 00000102", dmem_valid_8, dmem_addr_8);
        end
        sysreset = 1'b0;
        #1;
        vectors++;
        if (req_ready_8 !== 1'b1 || {rsp_valid_8, rsp_err_8, rsp_rdata_8, dmem_valid_8, dmem_we_8,
                                     dmem_addr_8, dmem_be_8, dmem_din_8} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: ready=%b valid=%b addr=%h rsp=%b, want ready=1 rest 0",
                     req_ready_8, dmem_valid_8, dmem_addr_8, rsp_valid_8);
        end
        @(negedge sysclk);
        sysreset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge sysclk);
            if (rsp_valid_8 || dmem_valid_8) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: %0d active cycles after reset, want 0", seen);
        end
    endtask

    initial begin
        req_valid_8 = 1'b0; req_valid_16 = 1'b0; req_valid_32 = 1'b0;
        dmem_ready_8 = 1'b0; dmem_ready_16 = 1'b0; dmem_ready_32 = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
        mem[10'h106] = 8'h34; mem[10'h107] = 8'hF2;
        mem[10'h200] = 8'h11; mem[10'h201] = 8'h22; mem[10'h202] = 8'h33; mem[10'h203] = 8'h80;
        mem[10'h300] = 8'h01; mem[10'h301] = 8'h02; mem[10'h302] = 8'h03; mem[10'h303] = 8'h84;

        test_reset();
        test_store_w8();
        test_load_w8();
        test_narrow_w32();
        test_errors();
        test_stall_w16();
        test_timeout_w16();
        test_reset_midbeat();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
